cpu_pwr_ctrl: RTL and testbench
===============================

// Module: cpu_pwr_ctrl
// PURPOSE
//  Power-state controller for the cpu core. Watches core activity and gates the
//  core clock after a programmable idle window. Drains the core before gating and
//  runs a timed wake-up sequence. Keeps saturating residency counters for power
//  modeling. Sits beside cpu at top level: drives its clock-gate enable and stall.
// PARAMETERS
//  IDLE_THRESH  8   qualifying idle cycles before sleep entry (>=1)
//  WAKE_CYC     2   cycles clk_en is high with stall held before RUN (>=1)
//  CNT_W        32  width of residency counters
// PORTS
//  clk            in   1      single clock; all state on posedge
//  rst            in   1      asynchronous, active-high reset
//  cpu_busy       in   1      core has work in flight (fetch/exec/mem pending)
//  sleep_en       in   1      software enable for automatic gating
//  wake_req       in   1      wake event (irq/debug); level, sampled each cycle
//  stats_clr      in   1      synchronous clear of all counters
//  clk_en         out  1      core clock-gate enable (to ICG)
//  stall_req      out  1      core must stop issuing new fetches
//  pwr_state      out  2      current state (encoding below)
//  active_cycles  out  CNT_W  cycles with clk_en=1, saturating
//  gated_cycles   out  CNT_W  cycles in GATED, saturating
//  wake_count     out  16     GATED->WAKE transitions, saturating
//  debug          out  16     {pwr_state, clk_en, stall_req, 4'b0, wake_count[7:0]}
// BEHAVIOUR
//  States: RUN=0, DRAIN=1, GATED=2, WAKE=3. Outputs decoded from state register only:
//   RUN: clk_en=1 stall=0 | DRAIN: 1/1 | GATED: 0/1 | WAKE: 1/1.
//  Reset (async): state RUN, idle_cnt=0, wake_tmr=0, all counters 0 -> clk_en=1,
//   stall_req=0, pwr_state=0, debug=16'h2000.
//  RUN: qualify = sleep_en & ~cpu_busy & ~wake_req. qualify -> idle_cnt+1, else
//   idle_cnt<=0. qualify while idle_cnt==IDLE_THRESH-1 -> DRAIN, idle_cnt<=0.
//   wake_req in same cycle always blocks entry.
//  DRAIN: wake_req | ~sleep_en -> RUN (abort). Else ~cpu_busy -> GATED. Else stay.
//  GATED: wake_req | ~sleep_en -> WAKE, wake_count+1, wake_tmr<=0.
//  WAKE: wake_tmr+1 each cycle; at wake_tmr==WAKE_CYC-1 -> RUN. Not abortable.
//   New wake_req during WAKE ignored.
//  Latency: idle starts at edge 0 with sleep_en=1 -> DRAIN after edge IDLE_THRESH,
//   GATED after edge IDLE_THRESH+1 (cpu_busy=0). Wake: GATED + wake_req -> clk_en=1
//   one edge later; stall_req drops WAKE_CYC edges after that.
//  Counters: each cycle active_cycles+=clk_en, gated_cycles+=(state==GATED).
//   All saturate at all-ones, no wrap. stats_clr beats increment that cycle (->0).
//  Reset mid-sequence: any state returns to RUN asynchronously, clk_en=1 immediately.
// STRUCTURE
//  cpu_pwr_pkg: typedef enum logic [1:0] pwr_state_e {RUN,DRAIN,GATED,WAKE};
//   DEBUG_PAD constant 4'b0.
//  Sub-module sat_counter #(W) (clk, rst, inc, clr, q): used for all three counters.
//  FSM, idle_cnt ($clog2(IDLE_THRESH+1) bits), wake_tmr stay in cpu_pwr_ctrl.
// TESTING
//  1 rst pulse -> clk_en=1, stall_req=0, pwr_state=0, counters 0, debug=16'h2000.
//  2 sleep_en=1, cpu_busy=0 -> DRAIN after 8 edges, GATED after 9, clk_en=0;
//    10 GATED cycles -> gated_cycles=10.
//  3 GATED, wake_req 1 cycle -> WAKE next edge (clk_en=1, stall=1), RUN 2 edges
//    later, wake_count=1.
//  4 cpu_busy=1 at 5th idle cycle -> idle_cnt=0, RUN held; DRAIN with cpu_busy=1
//    for 4 cycles stays DRAIN, GATED on edge after busy drops; wake_req in DRAIN -> RUN.
//  5 CNT_W=4, 20 active cycles -> active_cycles=15 held; stats_clr during increment -> 0.
//  6 rst asserted in GATED between edges -> clk_en=1, pwr_state=0 without clock edge.

Source files
------------

// File: rtl/cpu_pwr_pkg.sv
// Shared types and helpers for the cpu power-state controller.
// Output decode lives here so the FSM and any future observers agree on it.
package cpu_pwr_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } pwr_state_e;

    localparam logic [3:0] DEBUG_PAD = 4'b0;

    function automatic logic state_clk_en(input pwr_state_e s);
        return s != GATED;
    endfunction

    function automatic logic state_stall(input pwr_state_e s);
        return s != RUN;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/cpu_pwr_ctrl.sv
// Core power-state controller: idle-window sleep entry, drain, clock gating and
// timed wake-up, plus saturating residency counters for power modeling.
module cpu_pwr_ctrl
    import cpu_pwr_pkg::*;
#(
    parameter int unsigned IDLE_THRESH = 8,
    parameter int unsigned WAKE_CYC    = 2,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_busy,
    input  logic             sleep_en,
    input  logic             wake_req,
    input  logic             stats_clr,
    output logic             clk_en,
    output logic             stall_req,
    output logic [1:0]       pwr_state,
    output logic [CNT_W-1:0] active_cycles,
    output logic [CNT_W-1:0] gated_cycles,
    output logic [15:0]      wake_count,
    output logic [15:0]      debug
);

    localparam int unsigned IDLE_W = $clog2(IDLE_THRESH + 1);
    localparam int unsigned WAKE_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
    localparam logic [IDLE_W-1:0] LAST_IDLE = IDLE_W'(IDLE_THRESH - 1);
    localparam logic [WAKE_W-1:0] LAST_WAKE = WAKE_W'(WAKE_CYC - 1);

    pwr_state_e        state, state_d;
    logic [IDLE_W-1:0] idle_cnt, idle_d;
    logic [WAKE_W-1:0] wake_tmr, tmr_d;
    logic              qualify;
    logic              wake_evt;

    // A wake request in the same cycle always blocks sleep entry.
    assign qualify = sleep_en & ~cpu_busy & ~wake_req;

    always_comb begin
        state_d  = state;
        idle_d   = idle_cnt;
        tmr_d    = wake_tmr;
        wake_evt = 1'b0;
        unique case (state)
            RUN: begin
                if (qualify) begin
                    if (idle_cnt == LAST_IDLE) begin
                        state_d = DRAIN;
                        idle_d  = '0;
                    end else begin
                        idle_d = idle_cnt + IDLE_W'(1);
                    end
                end else begin
                    idle_d = '0;
                end
            end
            DRAIN: begin
                if (wake_req || !sleep_en) begin
                    state_d = RUN;
                end else if (!cpu_busy) begin
                    state_d = GATED;
                end
            end
            GATED: begin
                if (wake_req || !sleep_en) begin
                    state_d  = WAKE;
                    tmr_d    = '0;
                    wake_evt = 1'b1;
                end
            end
            WAKE: begin
                if (wake_tmr == LAST_WAKE) begin
                    state_d = RUN;
                end else begin
                    tmr_d = wake_tmr + WAKE_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are registered from the next state so they always match the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            idle_cnt  <= '0;
            wake_tmr  <= '0;
            clk_en    <= 1'b1;
            stall_req <= 1'b0;
        end else begin
            state     <= state_d;
            idle_cnt  <= idle_d;
            wake_tmr  <= tmr_d;
            clk_en    <= state_clk_en(state_d);
            stall_req <= state_stall(state_d);
        end
    end

    assign pwr_state = state;

    sat_counter #(.W(CNT_W)) u_active_cnt (
        .clk (clk),
        .rst (rst),
        .inc (clk_en),
        .clr (stats_clr),
        .q   (active_cycles)
    );

    sat_counter #(.W(CNT_W)) u_gated_cnt (
        .clk (clk),
        .rst (rst),
        .inc (state == GATED),
        .clr (stats_clr),
        .q   (gated_cycles)
    );

    sat_counter #(.W(16)) u_wake_cnt (
        .clk (clk),
        .rst (rst),
        .inc (wake_evt),
        .clr (stats_clr),
        .q   (wake_count)
    );

    assign debug = {pwr_state, clk_en, stall_req, DEBUG_PAD, wake_count[7:0]};

endmodule

// File: tb/tb_cpu_pwr_ctrl.sv
// Directed bench for cpu_pwr_ctrl; a second narrow-counter instance shares the stimulus.
module tb_cpu_pwr_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cpu_busy = 1'b0;
    logic sleep_en = 1'b0;
    logic wake_req = 1'b0;
    logic stats_clr = 1'b0;

    logic        clk_en, stall_req;
    logic [1:0]  pwr_state;
    logic [31:0] active_cycles, gated_cycles;
    logic [15:0] wake_count, debug;

    logic        n_clk_en, n_stall_req;
    logic [1:0]  n_pwr_state;
    logic [3:0]  n_active_cycles, n_gated_cycles;
    logic [15:0] n_wake_count, n_debug;

    int checks = 0;
    int errors = 0;

    cpu_pwr_ctrl #(.IDLE_THRESH(8), .WAKE_CYC(2), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_busy      (cpu_busy),
        .sleep_en      (sleep_en),
        .wake_req      (wake_req),
        .stats_clr     (stats_clr),
        .clk_en        (clk_en),
        .stall_req     (stall_req),
        .pwr_state     (pwr_state),
        .active_cycles (active_cycles),
        .gated_cycles  (gated_cycles),
        .wake_count    (wake_count),
        .debug         (debug)
    );

    cpu_pwr_ctrl #(.IDLE_THRESH(8), .WAKE_CYC(2), .CNT_W(4)) dut_n (
        .clk           (clk),
        .rst           (rst),
        .cpu_busy      (cpu_busy),
        .sleep_en      (sleep_en),
        .wake_req      (wake_req),
        .stats_clr     (stats_clr),
        .clk_en        (n_clk_en),
        .stall_req     (n_stall_req),
        .pwr_state     (n_pwr_state),
        .active_cycles (n_active_cycles),
        .gated_cycles  (n_gated_cycles),
        .wake_count    (n_wake_count),
        .debug         (n_debug)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset
        #2 rst = 1'b1;
        #1;
        chk("rst_clk_en", 32'(clk_en), 32'd1);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_state", 32'(pwr_state), 32'd0);
        tick(2);
        rst = 1'b0;
        chk("rst_active", active_cycles, 32'd0);
        chk("rst_gated", gated_cycles, 32'd0);
        chk("rst_wakes", 32'(wake_count), 32'd0);
        chk("rst_debug", 32'(debug), 32'h2000);

        // 2: idle window -> DRAIN after 8 edges, GATED after 9
        sleep_en = 1'b1;
        tick(7);
        chk("idle7_state", 32'(pwr_state), 32'd0);
        tick(1);
        chk("drain_state", 32'(pwr_state), 32'd1);
        chk("drain_clk_en", 32'(clk_en), 32'd1);
        chk("drain_stall", 32'(stall_req), 32'd1);
        tick(1);
        chk("gated_state", 32'(pwr_state), 32'd2);
        chk("gated_clk_en", 32'(clk_en), 32'd0);
        chk("gated_stall", 32'(stall_req), 32'd1);
        tick(10);
        chk("gated_cycles10", gated_cycles, 32'd10);
        chk("active_frozen", active_cycles, 32'd9);

        // 3: wake sequence
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        chk("wake_state", 32'(pwr_state), 32'd3);
        chk("wake_clk_en", 32'(clk_en), 32'd1);
        chk("wake_stall", 32'(stall_req), 32'd1);
        chk("wake_count1", 32'(wake_count), 32'd1);
        chk("gated_cycles11", gated_cycles, 32'd11);
        tick(1);
        chk("wake_hold", 32'(pwr_state), 32'd3);
        tick(1);
        chk("woke_state", 32'(pwr_state), 32'd0);
        chk("woke_stall", 32'(stall_req), 32'd0);
        chk("woke_debug", 32'(debug), 32'h2001);

        // 4: busy resets the idle window; busy holds DRAIN; wake aborts DRAIN
        tick(4);
        cpu_busy = 1'b1;
        tick(1);
        cpu_busy = 1'b0;
        tick(7);
        chk("busy_reset_run", 32'(pwr_state), 32'd0);
        tick(1);
        chk("drain2_state", 32'(pwr_state), 32'd1);
        cpu_busy = 1'b1;
        tick(4);
        chk("drain_busy_hold", 32'(pwr_state), 32'd1);
        cpu_busy = 1'b0;
        tick(1);
        chk("drain_to_gated", 32'(pwr_state), 32'd2);
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        chk("wake_count2", 32'(wake_count), 32'd2);
        tick(2);
        chk("run_again", 32'(pwr_state), 32'd0);
        tick(7);
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        chk("wake_blocks_entry", 32'(pwr_state), 32'd0);
        tick(7);
        chk("reidle_run", 32'(pwr_state), 32'd0);
        tick(1);
        chk("drain3_state", 32'(pwr_state), 32'd1);
        wake_req = 1'b1;
        tick(1);
        wake_req = 1'b0;
        chk("drain_abort", 32'(pwr_state), 32'd0);
        chk("drain_abort_stall", 32'(stall_req), 32'd0);
        chk("wake_count_still2", 32'(wake_count), 32'd2);

        // 5: saturation and clear on the 4-bit instance
        sleep_en = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(20);
        chk("sat_active", 32'(n_active_cycles), 32'd15);
        chk("wide_active", active_cycles, 32'd20);
        stats_clr = 1'b1;
        tick(1);
        stats_clr = 1'b0;
        chk("clr_narrow", 32'(n_active_cycles), 32'd0);
        chk("clr_wide", active_cycles, 32'd0);
        tick(1);
        chk("post_clr_count", 32'(n_active_cycles), 32'd1);

        // 6: asynchronous reset from GATED
        sleep_en = 1'b1;
        tick(9);
        chk("pre_rst_gated", 32'(pwr_state), 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_state", 32'(pwr_state), 32'd0);
        chk("async_clk_en", 32'(clk_en), 32'd1);
        chk("async_stall", 32'(stall_req), 32'd0);
        chk("async_gated_cnt", gated_cycles, 32'd0);
        rst = 1'b0;
        sleep_en = 1'b0;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
